bus_req_arbiter: RTL and testbench
==================================

// Module: bus_req_arbiter
// PURPOSE
//  Parametrised N-requester arbiter in front of the coherence bus controller. Picks one L1 requester
//  (dREN|dWEN) per bus transaction and holds the grant until the controller signals completion.
//  Modes: round-robin or fixed priority, each with starvation promotion. Replaces the implicit
//  single-winner selection inside the controller's IDLE state.
// PARAMETERS
//  CPUS          4    number of requesters (the bus controller instantiates it with NUM_HARTS*2)
//  RR_MODE       1    1 = round-robin, 0 = fixed priority (lowest index wins)
//  STARVE_LIMIT  16   cycles a pending requester waits before promotion; must be >= 2
//  CNT_W         $clog2(STARVE_LIMIT+1)  wait-counter width (derived localparam)
// PORTS
//  CLK          in   1              clock
//  nRST         in   1              async active-low reset
//  req          in   CPUS           per-requester request (dREN|dWEN from back_side_bus_if)
//  done         in   1              1-cycle pulse from bus controller: granted transaction finished
//  grant_valid  out  1              a grant is active
//  grant        out  CPUS           one-hot grant; all-zero when grant_valid=0
//  grant_idx    out  $clog2(CPUS)   binary index of granted requester; 0 when idle
//  starved      out  CPUS           requester's wait counter has reached STARVE_LIMIT
//  aborted      out  1              1-cycle pulse: granted requester dropped req before done
// BEHAVIOUR
//  Reset (async, nRST=0): all outputs 0, state ARB_IDLE, rr_ptr=0, wait counters 0.
//  All outputs are registered.
//  FSM states:
//   ARB_IDLE: if |req, register the winner and go to ARB_BUSY; grant asserts the next cycle (1-cycle latency).
//   ARB_BUSY: hold grant and grant_idx stable.
//    - done=1: clear grant and go to ARB_IDLE. This leaves 1 idle bubble; a new grant appears no
//      earlier than 2 cycles after done.
//    - req[grant_idx]=0 with done=0: release the grant, pulse aborted, go to ARB_IDLE.
//    - done and the req drop in the same cycle: counts as done, no abort.
//  Winner selection in ARB_IDLE:
//   (1) If any starved[i] & req[i]: lowest such index wins, regardless of mode.
//   (2) Otherwise RR_MODE=1: first req at or after rr_ptr, searching upward with wrap CPUS-1 -> 0.
//   (3) Otherwise RR_MODE=0: lowest req index wins.
//  rr_ptr update: on leaving ARB_BUSY (done or abort), rr_ptr <= grant_idx+1 mod CPUS.
//   This applies in both modes, so a mode change needs no reset.
//  Wait counters (one per requester):
//   - req[i] & ~grant[i]: increment, saturating at STARVE_LIMIT.
//   - req[i]=0 or grant[i]=1: clear to 0.
//   - starved[i] = (cnt[i]==STARVE_LIMIT).
//  done in ARB_IDLE is ignored (no state change, no error).
//  req=0 on all inputs: stay in ARB_IDLE, outputs 0.
//  nRST asserted mid-transaction: grant drops immediately (async). The bus controller is reset by
//  the same nRST, so no cleanup handshake exists.
//  Assertions (sim only): $onehot0(grant); grant_valid == |grant; done only while ARB_BUSY (warning).
// STRUCTURE
//  Shared package bus_arb_pkg:
//   - typedef enum logic [0:0] {ARB_IDLE, ARB_BUSY} arb_state_t
//   - function automatic rr_pick(req, ptr) returning a one-hot vector
//  Sub-module: arb_wait_counter (one saturating counter with clear; generate-instantiated CPUS times).
//  Remaining priority/one-hot-to-binary logic stays inline; no other sub-modules.
// TESTING
//  1) Reset: nRST=0 with req=4'b1111 -> grant=0, grant_valid=0, starved=0; release -> grant=4'b0001 after 1 cycle.
//  2) RR fairness: RR_MODE=1, req=4'b1111 held, done pulsed 2 cycles after each grant
//     -> grant order 0,1,2,3,0 with one idle cycle between grants.
//  3) Fixed priority with starvation: RR_MODE=0, STARVE_LIMIT=4, req=4'b1001, done every 3 cycles
//     -> req 0 wins repeatedly until starved[3]=1, then grant=4'b1000, after which cnt[3] clears.
//  4) Abort: grant=4'b0100 active, drop req[2] with done=0 -> aborted pulses 1 cycle,
//     grant=0 next cycle, rr_ptr=3.
//  5) Simultaneous: done and the req[grant_idx] drop in the same cycle -> aborted=0, normal release;
//     done while idle -> no effect.
//  6) Wrap and CPUS=8: rr_ptr=7, req=8'b0000_0011 -> grant_idx=0, then 1.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the coherence-bus request arbiter.
package bus_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int MAX_CPUS = 32;
  localparam int MAX_IDX_W = $clog2(MAX_CPUS);

  // One-hot of the first set req bit at or after ptr, wrapping at n.
  // Walks downward so the closest candidate to ptr is the last one written.
  function automatic logic [MAX_CPUS-1:0] rr_pick(input logic [MAX_CPUS-1:0] req,
                                                  input int ptr, input int n);
    logic [MAX_CPUS-1:0] oh;
    int idx;
    oh = '0;
    for (int k = MAX_CPUS - 1; k >= 0; k--) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (k < n && req[idx[MAX_IDX_W-1:0]]) begin
        oh = '0;
        oh[idx[MAX_IDX_W-1:0]] = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Per-requester wait counter: saturates at LIMIT, clears on clr, flags starvation.
module arb_wait_counter #(
  parameter int LIMIT = 16,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  output logic starved
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_starved;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr) w_cnt_nxt = '0;
    else if (inc && r_cnt != CNT_W'(LIMIT)) w_cnt_nxt = r_cnt + CNT_W'(1);
  end

  // Flag is registered from the next count so it tracks r_cnt exactly.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt     <= '0;
      r_starved <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_starved <= (w_cnt_nxt == CNT_W'(LIMIT));
    end
  end

  assign starved = r_starved;

endmodule

// File: rtl/bus_req_arbiter.sv
// N-requester bus arbiter: round-robin or fixed priority with starvation promotion,
// grant held from selection until the controller's done pulse or a requester abort.
module bus_req_arbiter
  import bus_arb_pkg::*;
#(
  parameter int CPUS         = 4,
  parameter int RR_MODE      = 1,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [CPUS-1:0]         req,
  input  logic                    done,
  output logic                    grant_valid,
  output logic [CPUS-1:0]         grant,
  output logic [$clog2(CPUS)-1:0] grant_idx,
  output logic [CPUS-1:0]         starved,
  output logic                    aborted
);

  localparam int IDX_W = $clog2(CPUS);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t       r_state;
  logic [CPUS-1:0]  r_grant;
  logic [IDX_W-1:0] r_grant_idx;
  logic             r_grant_valid;
  logic             r_aborted;
  logic [IDX_W-1:0] r_rr_ptr;

  logic [CPUS-1:0]  w_starved;
  logic [CPUS-1:0]  w_starve_req;
  logic [CPUS-1:0]  w_starve_oh;
  logic [CPUS-1:0]  w_rr_oh;
  logic [CPUS-1:0]  w_fix_oh;
  logic [CPUS-1:0]  w_win_oh;
  logic [IDX_W-1:0] w_win_idx;
  logic [IDX_W-1:0] w_next_ptr;
  logic             w_req_held;

  for (genvar g = 0; g < CPUS; g++) begin : g_wait
    arb_wait_counter #(
      .LIMIT(STARVE_LIMIT),
      .CNT_W(CNT_W)
    ) u_wait (
      .CLK    (CLK),
      .nRST   (nRST),
      .inc    (req[g] & ~r_grant[g]),
      .clr    (~req[g] | r_grant[g]),
      .starved(w_starved[g])
    );
  end

  // Starved requesters beat the normal policy; lowest starved index first.
  assign w_starve_req = w_starved & req;
  assign w_starve_oh  = w_starve_req & (~w_starve_req + CPUS'(1));
  assign w_fix_oh     = req & (~req + CPUS'(1));
  assign w_rr_oh      = CPUS'(rr_pick(MAX_CPUS'(req), int'(r_rr_ptr), CPUS));

  always_comb begin
    if (|w_starve_req)     w_win_oh = w_starve_oh;
    else if (RR_MODE != 0) w_win_oh = w_rr_oh;
    else                   w_win_oh = w_fix_oh;
  end

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < CPUS; i++)
      if (w_win_oh[i]) w_win_idx = w_win_idx | IDX_W'(i);
  end

  assign w_next_ptr = (r_grant_idx == IDX_W'(CPUS - 1)) ? '0 : r_grant_idx + IDX_W'(1);
  assign w_req_held = req[r_grant_idx];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state       <= ARB_IDLE;
      r_grant       <= '0;
      r_grant_idx   <= '0;
      r_grant_valid <= 1'b0;
      r_aborted     <= 1'b0;
      r_rr_ptr      <= '0;
    end else begin
      r_aborted <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (|req) begin
            r_state       <= ARB_BUSY;
            r_grant       <= w_win_oh;
            r_grant_idx   <= w_win_idx;
            r_grant_valid <= 1'b1;
          end
        end
        ARB_BUSY: begin
          // done wins over a simultaneous req drop, so that case is not an abort.
          if (done || !w_req_held) begin
            r_state       <= ARB_IDLE;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= w_next_ptr;
            r_aborted     <= !done;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign grant_valid = r_grant_valid;
  assign grant       = r_grant;
  assign grant_idx   = r_grant_idx;
  assign starved     = w_starved;
  assign aborted     = r_aborted;

`ifndef SYNTHESIS
  a_grant_onehot: assert property (@(posedge CLK) disable iff (!nRST) $onehot0(r_grant));
  a_valid_match:  assert property (@(posedge CLK) disable iff (!nRST) r_grant_valid == |r_grant);
  a_done_busy:    assert property (@(posedge CLK) disable iff (!nRST) done |-> r_state == ARB_BUSY)
                  else $warning("bus_req_arbiter: done seen while idle, ignored");
`endif

endmodule

// File: tb/tb_bus_req_arbiter.sv
// Bench for bus_req_arbiter: three configurations (RR/4, fixed/4 with short starvation, RR/8),
// directed scenarios with literal expectations, then random traffic against a queue-free model.
module tb_bus_req_arbiter;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic [3:0] req_a = '0, req_b = '0;
  logic [7:0] req_c = '0;
  logic       done_a = 1'b0, done_b = 1'b0, done_c = 1'b0;

  logic       gv_a, gv_b, gv_c, ab_a, ab_b, ab_c;
  logic [3:0] gr_a, gr_b, st_a, st_b;
  logic [7:0] gr_c, st_c;
  logic [1:0] ix_a, ix_b;
  logic [2:0] ix_c;

  bus_req_arbiter #(.CPUS(4), .RR_MODE(1), .STARVE_LIMIT(16)) u_a (
    .CLK(CLK), .nRST(nRST), .req(req_a), .done(done_a), .grant_valid(gv_a),
    .grant(gr_a), .grant_idx(ix_a), .starved(st_a), .aborted(ab_a));
  bus_req_arbiter #(.CPUS(4), .RR_MODE(0), .STARVE_LIMIT(4)) u_b (
    .CLK(CLK), .nRST(nRST), .req(req_b), .done(done_b), .grant_valid(gv_b),
    .grant(gr_b), .grant_idx(ix_b), .starved(st_b), .aborted(ab_b));
  bus_req_arbiter #(.CPUS(8), .RR_MODE(1), .STARVE_LIMIT(16)) u_c (
    .CLK(CLK), .nRST(nRST), .req(req_c), .done(done_c), .grant_valid(gv_c),
    .grant(gr_c), .grant_idx(ix_c), .starved(st_c), .aborted(ab_c));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int  nn(int k);  return (k == 2) ? 8 : 4;  endfunction
  function automatic int  lim(int k); return (k == 1) ? 4 : 16; endfunction
  function automatic bit  rrm(int k); return k != 1;            endfunction

  function automatic logic [7:0] in_req(int k);
    case (k)
      0:       return {4'b0, req_a};
      1:       return {4'b0, req_b};
      default: return req_c;
    endcase
  endfunction

  function automatic bit in_done(int k);
    case (k)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic bit req_bit(int k, int i);
    logic [7:0] r;
    r = in_req(k);
    return r[i];
  endfunction

  bit m_gv  [3];
  bit m_ab  [3];
  int m_gidx[3];
  int m_ptr [3];
  int m_cnt [3][8];

  function automatic int pick(int k);
    for (int i = 0; i < nn(k); i++)
      if (req_bit(k, i) && m_cnt[k][i] == lim(k)) return i;
    if (rrm(k)) begin
      for (int j = 0; j < nn(k); j++)
        if (req_bit(k, (m_ptr[k] + j) % nn(k))) return (m_ptr[k] + j) % nn(k);
    end
    for (int i = 0; i < nn(k); i++)
      if (req_bit(k, i)) return i;
    return 0;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k < 3; k++) begin
        m_gv[k] <= 1'b0; m_ab[k] <= 1'b0; m_gidx[k] <= 0; m_ptr[k] <= 0;
        for (int i = 0; i < 8; i++) m_cnt[k][i] <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_ab[k] <= 1'b0;
        for (int i = 0; i < 8; i++) begin
          if (i < nn(k) && req_bit(k, i) && !(m_gv[k] && m_gidx[k] == i))
            m_cnt[k][i] <= (m_cnt[k][i] >= lim(k)) ? lim(k) : m_cnt[k][i] + 1;
          else
            m_cnt[k][i] <= 0;
        end
        if (!m_gv[k]) begin
          if (in_req(k) != 8'h0) begin
            m_gv[k]   <= 1'b1;
            m_gidx[k] <= pick(k);
          end
        end else if (in_done(k) || !req_bit(k, m_gidx[k])) begin
          m_gv[k]   <= 1'b0;
          m_gidx[k] <= 0;
          m_ptr[k]  <= (m_gidx[k] + 1) % nn(k);
          m_ab[k]   <= !in_done(k);
        end
      end
    end
  end

  typedef struct packed {
    logic       gv;
    logic [7:0] grant;
    logic [2:0] idx;
    logic [7:0] st;
    logic       ab;
  } obs_t;

  function automatic obs_t obs(int k);
    obs_t o;
    case (k)
      0: begin o.gv = gv_a; o.grant = {4'b0, gr_a}; o.idx = {1'b0, ix_a}; o.st = {4'b0, st_a}; o.ab = ab_a; end
      1: begin o.gv = gv_b; o.grant = {4'b0, gr_b}; o.idx = {1'b0, ix_b}; o.st = {4'b0, st_b}; o.ab = ab_b; end
      default: begin o.gv = gv_c; o.grant = gr_c; o.idx = ix_c; o.st = st_c; o.ab = ab_c; end
    endcase
    return o;
  endfunction

  function automatic obs_t expect_obs(int k);
    obs_t e;
    e.gv    = m_gv[k];
    e.grant = m_gv[k] ? 8'(1 << m_gidx[k]) : 8'h0;
    e.idx   = 3'(m_gidx[k]);
    for (int i = 0; i < 8; i++) e.st[i] = (i < nn(k)) && (m_cnt[k][i] == lim(k));
    e.ab    = m_ab[k];
    return e;
  endfunction

  always @(negedge CLK) begin
    for (int k = 0; k < 3; k++) begin
      obs_t a, e;
      a = obs(k);
      e = expect_obs(k);
      chk("grant_valid", k, 32'(a.gv),    32'(e.gv));
      chk("grant",       k, 32'(a.grant), 32'(e.grant));
      chk("grant_idx",   k, 32'(a.idx),   32'(e.idx));
      chk("starved",     k, 32'(a.st),    32'(e.st));
      chk("aborted",     k, 32'(a.ab),    32'(e.ab));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int rr_exp[5];
    int fp_exp[3];
    rr_exp = '{0, 1, 2, 3, 0};
    fp_exp = '{0, 0, 3};

    // Reset held with all requesting: outputs stay zero, first grant one cycle after release.
    req_a = 4'b1111;
    repeat (2) @(negedge CLK);
    chk("rst_grant", 0, 32'(gr_a), 32'h0);
    chk("rst_gv",    0, 32'(gv_a), 32'h0);
    chk("rst_starv", 0, 32'(st_a), 32'h0);
    #1 nRST = 1'b1;
    @(negedge CLK);
    chk("first_grant", 0, 32'(gr_a), 32'h1);

    // Round-robin order with one bubble after each done.
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge CLK);
      chk("rr_order", 0, 32'(ix_a), 32'(rr_exp[k]));
      chk("rr_gv",    0, 32'(gv_a), 32'h1);
      @(negedge CLK); #1 done_a = 1'b1;
      @(negedge CLK);
      chk("rr_bubble", 0, 32'(gv_a), 32'h0);
      #1 done_a = 1'b0;
    end

    // Abort of requester 2, then pointer must sit at 3.
    req_a = 4'b0100;
    @(negedge CLK);
    chk("abort_grant", 0, 32'(gr_a), 32'h4);
    #1 req_a = 4'b0000;
    @(negedge CLK);
    chk("abort_pulse", 0, 32'(ab_a), 32'h1);
    chk("abort_gv",    0, 32'(gv_a), 32'h0);
    #1 req_a = 4'b1011;
    @(negedge CLK);
    chk("abort_once",  0, 32'(ab_a), 32'h0);
    chk("ptr_after_ab", 0, 32'(gr_a), 32'h8);

    // done together with req drop is a normal release; done while idle is ignored.
    #1 begin done_a = 1'b1; req_a = 4'b0000; end
    @(negedge CLK);
    chk("simul_noab", 0, 32'(ab_a), 32'h0);
    chk("simul_gv",   0, 32'(gv_a), 32'h0);
    #1 done_a = 1'b0;
    @(negedge CLK);
    #1 done_a = 1'b1;
    @(negedge CLK);
    chk("idle_done_gv", 0, 32'(gv_a), 32'h0);
    chk("idle_done_ab", 0, 32'(ab_a), 32'h0);
    #1 begin done_a = 1'b0; req_a = 4'b1111; end
    @(negedge CLK);
    chk("ptr_wrap4", 0, 32'(ix_a), 32'h0);

    // Mid-transaction reset drops the grant without waiting for a clock.
    #1 nRST = 1'b0;
    #1 chk("async_grant", 0, 32'(gr_a), 32'h0);
    chk("async_gv", 0, 32'(gv_a), 32'h0);
    @(negedge CLK);
    #1 begin nRST = 1'b1; req_a = 4'b0000; end

    // Fixed priority: requester 3 only wins once its wait counter saturates.
    @(negedge CLK);
    #1 req_b = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("fp_order", 1, 32'(ix_b), 32'(fp_exp[k]));
      if (k == 2) chk("fp_starved", 1, 32'(st_b[3]), 32'h1);
      @(negedge CLK);
      if (k == 2) chk("fp_starv_clr", 1, 32'(st_b[3]), 32'h0);
      #1 done_b = 1'b1;
      @(negedge CLK);
      chk("fp_bubble", 1, 32'(gv_b), 32'h0);
      #1 done_b = 1'b0;
    end
    req_b = 4'b0000;

    // CPUS=8 wrap: grant 6 leaves pointer at 7, then 0 and 1 win in order.
    req_c = 8'b0100_0000;
    @(negedge CLK);
    chk("w8_six", 2, 32'(ix_c), 32'h6);
    #1 done_c = 1'b1;
    @(negedge CLK);
    #1 begin done_c = 1'b0; req_c = 8'b0000_0011; end
    @(negedge CLK);
    chk("w8_wrap0", 2, 32'(ix_c), 32'h0);
    #1 done_c = 1'b1;
    @(negedge CLK);
    #1 done_c = 1'b0;
    @(negedge CLK);
    chk("w8_then1", 2, 32'(ix_c), 32'h1);
    #1 req_c = 8'h00;

    // Random traffic; done only while the model says a grant is live.
    for (int n = 0; n < 3000; n++) begin
      @(negedge CLK);
      #1;
      if (n == 1500) nRST = 1'b0;
      if (n == 1502) nRST = 1'b1;
      if ($urandom_range(2) == 0) req_a = 4'($urandom);
      if ($urandom_range(2) == 0) req_b = 4'($urandom);
      if ($urandom_range(2) == 0) req_c = 8'($urandom) & 8'($urandom);
      done_a = m_gv[0] && ($urandom_range(2) == 0);
      done_b = m_gv[1] && ($urandom_range(2) == 0);
      done_c = m_gv[2] && ($urandom_range(2) == 0);
    end

    @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
